display: RTL and testbench
==========================

Name: display

Overview:
- Time-multiplexed 8-digit seven-segment driver for the vending-machine front panel.
- Shows three values:
  - the coin total inserted so far (digits 7..5);
  - the selected item code (digit 4);
  - the item price, or the change once charging is indicated (digits 2..0).
- Sits between the vending controller (op_start, charge_ind, coin_val, buy_one, buy_two) and the board's common-anode display pins.

Parameters:
- SCAN_DIV, default 100000: clock cycles each digit stays lit before the scan advances. Must be ≥1. Benches use 1.
- PRICE_ONE, default 5: price of item 1 in 0.5-unit steps (5 = 2.5).
- PRICE_TWO, default 10: price of item 2 in 0.5-unit steps (10 = 5.0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- light  in  1  display enable; 0 blanks every digit.
- op_start  in  1  machine session active; 0 blanks every digit.
- charge_ind  in  1  when 1, digits 2..0 show change instead of price.
- coin_val  in  6  accumulated coin total in 0.5-unit steps (0..63, i.e. 0.0..31.5).
- buy_one  in  1  item 1 selected.
- buy_two  in  1  item 2 selected.
- seg  out  8  segment pattern, active-low: bit7=dp, bits6..0 = g,f,e,d,c,b,a.
- an  out  8  digit enables, active-low: an[7] is the leftmost digit.

Behaviour:
- Reset (rst_n=0, async): scan counter=0, digit index=0, seg=8'hFF, an=8'hFF.
- Scan:
  - The counter counts 0..SCAN_DIV-1.
  - On wrap, the digit index increments 0→7→0.
  - seg and an are registered: they update one cycle after the index or inputs change.
- Blanking: light=0 or op_start=0 forces an=8'hFF and seg=8'hFF on the next edge. The scan keeps running.
- Otherwise an has exactly one low bit, at the current index. seg carries that digit's pattern.
- Inputs are sampled combinationally each cycle. No input latching.
- Amount A = coin_val:
  - digit7 = tens of A/2, blanked if 0;
  - digit6 = ones of A/2, with dp lit;
  - digit5 = 5 if A is odd, else 0.
- Selection:
  - buy_one=1 → item 1, price P=PRICE_ONE, digit4 = "1".
  - else buy_two=1 → item 2, P=PRICE_TWO, digit4 = "2".
  - else no item: P=0, digit4 blank.
  - buy_one has priority if both are high.
- digit3: always blank.
- Value V for digits 2..0:
  - charge_ind=0: V=P.
  - charge_ind=1: V = coin_val−P, saturating at 0 when coin_val<P. With no item selected, V=coin_val.
  - Encoded like A: digit2 = tens (blanked if 0), digit1 = ones with dp, digit0 = tenth (5 or 0).
- Glyph codes (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99;
  - 5=92, 6=82, 7=F8, 8=80, 9=90;
  - blank=FF.
  - Lit dp clears bit7.
- Arithmetic:
  - Use 7-bit unsigned subtraction for change.
  - Binary-to-BCD covers 0..31.
  - No wrap-around is permitted.
- Mid-operation reset: outputs go to FF immediately. Scanning restarts at digit 0 after release.

Test Plan:
- Reset then idle: rst_n=0, SCAN_DIV=1 → seg=FF, an=FF. After release with op_start=0 → outputs stay FF across 16 cycles.
- Amount display: op_start=1, light=1, coin_val=7 → over 8 scan slots:
  - an=7F seg=FF (blank tens);
  - an=BF seg=30 ("3.");
  - an=DF seg=92 ("5");
  - an=EF seg=FF;
  - digits 2..0 = FF, 40 ("0."), C0.
- coin_val=12, buy_one=1 → digit6=02 ("6."), digit5=C0, digit4=F9, digits 2..0 = FF, 24 ("2."), 92.
- Then charge_ind=1 → change 7 (3.5): digit2=FF, digit1=30 ("3."), digit0=92.
- Change saturation and priority: coin_val=3, buy_one=1, buy_two=1, charge_ind=1 → digit4=F9, digits 2..0 = FF, 40, C0.
- light=0 with any inputs → an=FF, seg=FF on the next edge. Restoring light=1 resumes at the current scan index.

Source files
------------

// File: rtl/display.sv
// -----------------------------------------------------------------------------
// display
//   Time-multiplexed 8-digit seven-segment driver for the vending-machine
//   front panel. Digits 7..5 show the coin total, digit 4 the selected item,
//   digit 3 is always blank, and digits 2..0 show the price or, while
//   charging, the change. Values are kept in 0.5-unit steps and shown as
//   tens / ones-with-dp / tenth (5 or 0).
//
// Ports
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   light      in  1  display enable, 0 blanks all digits
//   op_start   in  1  session active, 0 blanks all digits
//   charge_ind in  1  1 = digits 2..0 show change instead of price
//   coin_val   in  6  accumulated coin total, 0.5-unit steps
//   buy_one    in  1  item 1 selected (priority over buy_two)
//   buy_two    in  1  item 2 selected
//   seg        out 8  active-low segments, bit7=dp, bits6..0=g..a
//   an         out 8  active-low digit enables, an[7] leftmost
// -----------------------------------------------------------------------------
module display #(
    parameter int SCAN_DIV  = 100000,
    parameter int PRICE_ONE = 5,
    parameter int PRICE_TWO = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       light,
    input  logic       op_start,
    input  logic       charge_ind,
    input  logic [5:0] coin_val,
    input  logic       buy_one,
    input  logic       buy_two,
    output logic [7:0] seg,
    output logic [7:0] an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0] P_ONE = 7'(PRICE_ONE);
    localparam logic [6:0] P_TWO = 7'(PRICE_TWO);

    localparam logic [3:0] D_BLANK = 4'd10;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Glyph lookup, dp off; anything outside 0..9 is blank.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Tens digit of a 0..31 whole-unit value.
    function automatic logic [3:0] tens_of(input logic [4:0] v);
        logic [3:0] t;
        if (v >= 5'd30) begin
            t = 4'd3;
        end else if (v >= 5'd20) begin
            t = 4'd2;
        end else if (v >= 5'd10) begin
            t = 4'd1;
        end else begin
            t = 4'd0;
        end
        return t;
    endfunction

    // Ones digit of a 0..31 whole-unit value.
    function automatic logic [3:0] ones_of(input logic [4:0] v);
        logic [4:0] r;
        if (v >= 5'd30) begin
            r = v - 5'd30;
        end else if (v >= 5'd20) begin
            r = v - 5'd20;
        end else if (v >= 5'd10) begin
            r = v - 5'd10;
        end else begin
            r = v;
        end
        return r[3:0];
    endfunction

    // Tens glyph, blanked when the tens digit is zero.
    function automatic logic [7:0] tens_glyph(input logic [4:0] v);
        logic [3:0] t;
        t = tens_of(v);
        return (t == 4'd0) ? glyph(D_BLANK) : glyph(t);
    endfunction

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    seg_r;
    logic [7:0]    an_r;

    logic [6:0] price_s;
    logic [7:0] item_glyph_s;
    logic [6:0] coin7_s;
    logic [6:0] diff_s;
    logic [5:0] val_s;
    logic [7:0] digit_seg_s;
    logic [7:0] digit_an_s;
    logic       blank_s;

    assign coin7_s = {1'b0, coin_val};
    assign blank_s = ~light | ~op_start;

    // Item selection: buy_one wins, otherwise buy_two, otherwise nothing.
    always_comb begin
        price_s      = 7'd0;
        item_glyph_s = glyph(D_BLANK);
        if (buy_one) begin
            price_s      = P_ONE;
            item_glyph_s = glyph(4'd1);
        end else if (buy_two) begin
            price_s      = P_TWO;
            item_glyph_s = glyph(4'd2);
        end else begin
            price_s      = 7'd0;
            item_glyph_s = glyph(D_BLANK);
        end
    end

    // Lower value: price, or change saturating at zero while charging.
    always_comb begin
        diff_s = 7'd0;
        if (!charge_ind) begin
            diff_s = price_s;
        end else if (coin7_s < price_s) begin
            diff_s = 7'd0;
        end else begin
            diff_s = coin7_s - price_s;
        end
        // Clamp to the 6-bit display range in case a price parameter is large.
        val_s = diff_s[6] ? 6'h3F : diff_s[5:0];
    end

    // Pattern and enable for the digit at the current scan index.
    always_comb begin
        digit_seg_s = SEG_OFF;
        digit_an_s  = ~(8'h01 << idx_r);
        case (idx_r)
            3'd7:    digit_seg_s = tens_glyph(coin_val[5:1]);
            3'd6:    digit_seg_s = glyph(ones_of(coin_val[5:1])) & 8'h7F;
            3'd5:    digit_seg_s = coin_val[0] ? glyph(4'd5) : glyph(4'd0);
            3'd4:    digit_seg_s = item_glyph_s;
            3'd3:    digit_seg_s = SEG_OFF;
            3'd2:    digit_seg_s = tens_glyph(val_s[5:1]);
            3'd1:    digit_seg_s = glyph(ones_of(val_s[5:1])) & 8'h7F;
            3'd0:    digit_seg_s = val_s[0] ? glyph(4'd5) : glyph(4'd0);
            default: digit_seg_s = SEG_OFF;
        endcase
    end

    // Scan divider and digit index; keeps running while blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= 3'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            idx_r <= idx_r;
        end
    end

    // Registered panel outputs, forced dark when blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_OFF;
            an_r  <= 8'hFF;
        end else if (blank_s) begin
            seg_r <= SEG_OFF;
            an_r  <= 8'hFF;
        end else begin
            seg_r <= digit_seg_s;
            an_r  <= digit_an_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_display.sv
module tb_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       light;
    logic       op_start;
    logic       charge_ind;
    logic [5:0] coin_val;
    logic       buy_one;
    logic       buy_two;
    logic [7:0] seg;
    logic [7:0] an;

    always #5 clk = ~clk;

    display #(
        .SCAN_DIV (1),
        .PRICE_ONE(5),
        .PRICE_TWO(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .light     (light),
        .op_start  (op_start),
        .charge_ind(charge_ind),
        .coin_val  (coin_val),
        .buy_one   (buy_one),
        .buy_two   (buy_two),
        .seg       (seg),
        .an        (an)
    );

    int checks = 0;
    int passed = 0;
    int idx_m  = 0;
    logic [15:0] sb[$];

    // Expected digit tables, packed {d7,d6,d5,d4,d3,d2,d1,d0}.
    localparam logic [63:0] T_AMT7   = 64'hFF_30_92_FF_FF_FF_40_C0;
    localparam logic [63:0] T_B1_12  = 64'hFF_02_C0_F9_FF_FF_24_92;
    localparam logic [63:0] T_CHG_7  = 64'hFF_02_C0_F9_FF_FF_30_92;
    localparam logic [63:0] T_SAT    = 64'hFF_79_92_F9_FF_FF_40_C0;
    localparam logic [63:0] T_B2_63  = 64'hB0_79_92_A4_FF_FF_12_C0;
    localparam logic [63:0] T_B2_63C = 64'hB0_79_92_A4_FF_A4_02_92;
    localparam logic [63:0] T_NONE25 = 64'hF9_24_92_FF_FF_F9_24_92;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One scan slot: push expectation, let the DUT clock, pop and compare.
    task automatic slot(input string tag, input logic [63:0] tbl, input bit blank);
        logic [7:0]  ea;
        logic [7:0]  es;
        logic [15:0] e;
        if (blank) begin
            ea = 8'hFF;
            es = 8'hFF;
        end else begin
            ea = ~(8'h01 << idx_m);
            es = tbl[idx_m*8 +: 8];
        end
        sb.push_back({ea, es});
        idx_m = (idx_m + 1) % 8;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check8({tag, "_an"}, an, e[15:8]);
            check8({tag, "_seg"}, seg, e[7:0]);
        end
    endtask

    task automatic run_slots(input string tag, input logic [63:0] tbl, input bit blank, input int n);
        for (int i = 0; i < n; i++) begin
            slot(tag, tbl, blank);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        light      = 1'b0;
        op_start   = 1'b0;
        charge_ind = 1'b0;
        coin_val   = 6'd0;
        buy_one    = 1'b0;
        buy_two    = 1'b0;

        #12;
        check8("reset_an", an, 8'hFF);
        check8("reset_seg", seg, 8'hFF);

        @(negedge clk);
        rst_n = 1'b1;
        idx_m = 0;

        // Idle session: everything stays dark.
        light = 1'b1;
        run_slots("idle", 64'h0, 1'b1, 16);

        // Coin total 3.5, no item.
        op_start = 1'b1;
        coin_val = 6'd7;
        run_slots("amt7", T_AMT7, 1'b0, 8);

        // Item 1 price 2.5 with 6.0 inserted.
        coin_val = 6'd12;
        buy_one  = 1'b1;
        run_slots("buy1", T_B1_12, 1'b0, 8);

        // Change 3.5.
        charge_ind = 1'b1;
        run_slots("chg7", T_CHG_7, 1'b0, 8);

        // Saturated change, buy_one priority.
        coin_val = 6'd3;
        buy_two  = 1'b1;
        run_slots("sat", T_SAT, 1'b0, 8);

        // Max coin, item 2 price 5.0, then change 26.5.
        coin_val   = 6'd63;
        buy_one    = 1'b0;
        charge_ind = 1'b0;
        run_slots("b2", T_B2_63, 1'b0, 8);
        charge_ind = 1'b1;
        run_slots("b2chg", T_B2_63C, 1'b0, 8);

        // No item while charging: change equals coin total.
        buy_two  = 1'b0;
        coin_val = 6'd25;
        run_slots("none", T_NONE25, 1'b0, 5);

        // Blank via light; scan keeps advancing and resumes mid-sequence.
        light = 1'b0;
        run_slots("light_off", 64'h0, 1'b1, 3);
        light = 1'b1;
        run_slots("resume", T_NONE25, 1'b0, 8);

        // Blank via op_start.
        op_start = 1'b0;
        run_slots("op_off", 64'h0, 1'b1, 2);
        op_start = 1'b1;
        run_slots("op_on", T_NONE25, 1'b0, 3);

        // Mid-operation reset: immediate dark outputs, restart at digit 0.
        #3;
        rst_n = 1'b0;
        #1;
        check8("midrst_an", an, 8'hFF);
        check8("midrst_seg", seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        idx_m = 0;
        run_slots("after_rst", T_NONE25, 1'b0, 8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
